slant_lane_tx: RTL and testbench

- Parametrised multi-lane transmit framer for the drone camera link. Reads Y/C samples from LANES slant memory banks through a shared read port. Emits one symbol per lane per symbol slot, in this order:
  - a frame header pattern;
  - image data words, alternating Y and C;
  - an hsync pattern between lines.
- Sits between the slant frame memory and the lane serialisers. Adds start/abort control, done/status reporting and programmable geometry.

---
 rtl/slant_lane_tx_if.sv | 30 +++
 rtl/slant_lane_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_slant_lane_tx.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slant_lane_tx_if.sv
// Control, status, frame-memory read port and lane-symbol bus of the slant lane framer.
interface slant_lane_tx_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DW     = 5,
  parameter int unsigned SYM_W  = 6,
  parameter int unsigned ADDR_W = 17
);
  logic                     start;
  logic                     abort;
  logic                     frame_sel;
  logic [ADDR_W-2:0]        mem_raddr;
  logic                     mem_rsel;
  logic [LANES*DW-1:0]      mem_rdata;
  logic                     tx_valid;
  logic [LANES*SYM_W-1:0]   tx_data;
  logic                     busy;
  logic                     done;
  logic [11:0]              line_count;
  logic [15:0]              frame_count;

  modport master (
    input  start, abort, frame_sel, mem_rdata,
    output mem_raddr, mem_rsel, tx_valid, tx_data, busy, done, line_count, frame_count
  );

  modport slave (
    output start, abort, frame_sel, mem_rdata,
    input  mem_raddr, mem_rsel, tx_valid, tx_data, busy, done, line_count, frame_count
  );
endinterface

// File: rtl/slant_lane_tx.sv
// Multi-lane transmit framer: header pattern, Y/C data words read from slant banks,
// hsync patterns between lines; one symbol per lane per SYM_PERIOD-cycle slot.
module slant_lane_tx #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned DW          = 5,
  parameter int unsigned SYM_W       = 6,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned SYM_PERIOD  = 25,
  parameter int unsigned LINE_WORDS  = 160,
  parameter int unsigned TOTAL_WORDS = 76800,
  parameter int unsigned FRAME_PAT_W = 24,
  parameter logic [FRAME_PAT_W-1:0] FRAME0 = 24'haa8d55,
  parameter logic [FRAME_PAT_W-1:0] FRAME1 = 24'haab155,
  parameter int unsigned HSYNC_PAT_W = 8,
  parameter logic [HSYNC_PAT_W-1:0] HSYNC = 8'h55
) (
  input  logic           Cclk,
  input  logic           rstn,
  slant_lane_tx_if.master bus
);

  localparam int unsigned SC_W    = $clog2(SYM_PERIOD);
  localparam int unsigned PAT_MAX = (FRAME_PAT_W > HSYNC_PAT_W) ? FRAME_PAT_W : HSYNC_PAT_W;
  localparam int unsigned K_W     = $clog2(PAT_MAX);
  localparam int unsigned HI_W    = $clog2(FRAME_PAT_W);
  localparam int unsigned HS_W    = $clog2(HSYNC_PAT_W);
  localparam int unsigned LW_W    = $clog2(LINE_WORDS);
  localparam int unsigned TX_W    = LANES * SYM_W;
  localparam int unsigned RD_W    = LANES * DW;
  localparam int unsigned RA_W    = ADDR_W - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FHDR, ST_DATA, ST_HSYNC} state_t;

  state_t            state, state_d;
  logic [SC_W-1:0]   sc, sc_d;
  logic [K_W-1:0]    k, k_d;
  logic [ADDR_W-1:0] w, w_d;
  logic [LW_W-1:0]   lw, lw_d;
  logic              fsel, fsel_d;
  logic [RD_W-1:0]   hold, hold_d;
  logic [RA_W-1:0]   raddr_d;
  logic              rsel_d;
  logic              valid_d, busy_d, done_d;
  logic [TX_W-1:0]   data_d;
  logic [11:0]       line_d;
  logic [15:0]       frame_d;

  logic                   slot_end, hdr_last, hs_last, line_end, frame_end, prefetch;
  logic [FRAME_PAT_W-1:0] hdr_pat;
  logic [HI_W-1:0]        hdr_idx;
  logic [HS_W-1:0]        hs_idx;
  logic [ADDR_W-1:0]      pf_w;
  logic [TX_W-1:0]        data_sym;

  assign slot_end  = (sc == SC_W'(SYM_PERIOD - 1));
  assign hdr_last  = (k == K_W'(FRAME_PAT_W - 1));
  assign hs_last   = (k == K_W'(HSYNC_PAT_W - 1));
  assign line_end  = (lw == LW_W'(LINE_WORDS - 1));
  assign frame_end = (w == ADDR_W'(TOTAL_WORDS - 1));
  assign hdr_pat   = fsel ? FRAME1 : FRAME0;
  // pattern bit for the slot after the current one
  assign hdr_idx   = HI_W'(FRAME_PAT_W - 2) - HI_W'(k);
  assign hs_idx    = HS_W'(HSYNC_PAT_W - 2) - HS_W'(k);
  // word fetched during this slot; header keeps w at 0 for the first word
  assign pf_w      = (state == ST_FHDR) ? w : w + ADDR_W'(1);
  assign prefetch  = ((state == ST_FHDR)  && hdr_last) ||
                     ((state == ST_DATA)  && !line_end) ||
                     ((state == ST_HSYNC) && hs_last);

  // zero-extend each bank sample into its lane symbol
  always_comb begin
    data_sym = '0;
    for (int i = 0; i < LANES; i++) begin
      data_sym[i*SYM_W +: SYM_W] = SYM_W'(hold[i*DW +: DW]);
    end
  end

  // state register
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.start) state_d = ST_FHDR;
        ST_FHDR:  if (slot_end && hdr_last) state_d = ST_DATA;
        ST_DATA:  if (slot_end && line_end) state_d = frame_end ? ST_IDLE : ST_HSYNC;
        ST_HSYNC: if (slot_end && hs_last) state_d = ST_DATA;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // output and datapath next values
  always_comb begin
    sc_d    = sc;
    k_d     = k;
    w_d     = w;
    lw_d    = lw;
    fsel_d  = fsel;
    hold_d  = hold;
    raddr_d = bus.mem_raddr;
    rsel_d  = bus.mem_rsel;
    valid_d = 1'b0;
    data_d  = bus.tx_data;
    busy_d  = bus.busy;
    done_d  = 1'b0;
    line_d  = bus.line_count;
    frame_d = bus.frame_count;
    if (bus.abort) begin
      busy_d = 1'b0;
      data_d = '0;
    end else if (state == ST_IDLE) begin
      if (bus.start) begin
        busy_d  = 1'b1;
        sc_d    = '0;
        k_d     = '0;
        w_d     = '0;
        lw_d    = '0;
        fsel_d  = bus.frame_sel;
        line_d  = '0;
        valid_d = 1'b1;
        data_d  = {TX_W{bus.frame_sel ? FRAME1[FRAME_PAT_W-1] : FRAME0[FRAME_PAT_W-1]}};
      end
    end else begin
      sc_d = slot_end ? '0 : sc + SC_W'(1);
      if (prefetch && (sc == SC_W'(SYM_PERIOD - 4))) begin
        raddr_d = pf_w[ADDR_W-1:1];
        rsel_d  = pf_w[0];
      end
      if (prefetch && (sc == SC_W'(SYM_PERIOD - 2))) hold_d = bus.mem_rdata;
      if (slot_end) begin
        valid_d = 1'b1;
        case (state)
          ST_FHDR: begin
            if (hdr_last) begin
              k_d    = '0;
              data_d = data_sym;
            end else begin
              k_d    = k + K_W'(1);
              data_d = {TX_W{hdr_pat[hdr_idx]}};
            end
          end
          ST_DATA: begin
            if (line_end) begin
              line_d = bus.line_count + 12'd1;
              lw_d   = '0;
              if (frame_end) begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                data_d  = '0;
                done_d  = 1'b1;
                frame_d = bus.frame_count + 16'd1;
              end else begin
                k_d    = '0;
                data_d = {TX_W{HSYNC[HSYNC_PAT_W-1]}};
              end
            end else begin
              w_d    = w + ADDR_W'(1);
              lw_d   = lw + LW_W'(1);
              data_d = data_sym;
            end
          end
          ST_HSYNC: begin
            if (hs_last) begin
              k_d    = '0;
              w_d    = w + ADDR_W'(1);
              data_d = data_sym;
            end else begin
              k_d    = k + K_W'(1);
              data_d = {TX_W{HSYNC[hs_idx]}};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // datapath and output registers
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      sc              <= '0;
      k               <= '0;
      w               <= '0;
      lw              <= '0;
      fsel            <= 1'b0;
      hold            <= '0;
      bus.mem_raddr   <= '0;
      bus.mem_rsel    <= 1'b0;
      bus.tx_valid    <= 1'b0;
      bus.tx_data     <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.line_count  <= '0;
      bus.frame_count <= '0;
    end else begin
      sc              <= sc_d;
      k               <= k_d;
      w               <= w_d;
      lw              <= lw_d;
      fsel            <= fsel_d;
      hold            <= hold_d;
      bus.mem_raddr   <= raddr_d;
      bus.mem_rsel    <= rsel_d;
      bus.tx_valid    <= valid_d;
      bus.tx_data     <= data_d;
      bus.busy        <= busy_d;
      bus.done        <= done_d;
      bus.line_count  <= line_d;
      bus.frame_count <= frame_d;
    end
  end

endmodule

// File: tb/tb_slant_lane_tx.sv
// Bench for slant_lane_tx in a small geometry: banked memory model plus a slot-stream reference.
module tb_slant_lane_tx;
  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 5;
  localparam int unsigned SYM_W = 6;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned SP    = 5;
  localparam int unsigned LW    = 8;
  localparam int unsigned TW    = 32;
  localparam int unsigned TX_W  = LANES * SYM_W;
  localparam int unsigned RD_W  = LANES * DW;
  localparam int unsigned RA_W  = ADDR_W - 1;
  localparam int          SLOTS = 24 + TW + (TW / LW - 1) * 8;

  logic Cclk;
  logic rstn;
  int   checks;
  int   errors;
  int   mem_seed;

  logic [TX_W-1:0] exp_q[$];
  int              exp_nw[$];

  slant_lane_tx_if #(.LANES(LANES), .DW(DW), .SYM_W(SYM_W), .ADDR_W(ADDR_W)) bus ();

  slant_lane_tx #(
    .LANES(LANES), .DW(DW), .SYM_W(SYM_W), .ADDR_W(ADDR_W),
    .SYM_PERIOD(SP), .LINE_WORDS(LW), .TOTAL_WORDS(TW)
  ) dut (
    .Cclk(Cclk),
    .rstn(rstn),
    .bus (bus)
  );

  initial Cclk = 1'b0;
  always #5 Cclk = ~Cclk;

  function automatic logic [DW-1:0] samp(input int a, input int s, input int lane);
    return DW'((a * 7 + s * 13 + lane * 5 + mem_seed) % 32);
  endfunction

  function automatic logic [RD_W-1:0] mem_word(input int a, input int s);
    logic [RD_W-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = samp(a, s, l);
    return r;
  endfunction

  // bank memory with one cycle read latency
  always @(posedge Cclk) bus.mem_rdata <= mem_word(32'(bus.mem_raddr), 32'(bus.mem_rsel));

  // expected symbol per slot, and the word prefetched during that slot (-1 if none)
  task automatic build_expected(input bit fs);
    logic [23:0] pat;
    logic [7:0]  hs;
    logic [TX_W-1:0] sym;
    pat = fs ? 24'haab155 : 24'haa8d55;
    hs  = 8'h55;
    exp_q.delete();
    exp_nw.delete();
    for (int k = 0; k < 24; k++) begin
      exp_q.push_back({TX_W{pat[23-k]}});
      exp_nw.push_back(k == 23 ? 0 : -1);
    end
    for (int w = 0; w < TW; w++) begin
      for (int l = 0; l < LANES; l++) sym[l*SYM_W +: SYM_W] = SYM_W'(samp(w / 2, w % 2, l));
      exp_q.push_back(sym);
      exp_nw.push_back(((w + 1) % LW != 0) ? w + 1 : -1);
      if (((w + 1) % LW == 0) && (w + 1 < TW)) begin
        for (int k = 0; k < 8; k++) begin
          exp_q.push_back({TX_W{hs[7-k]}});
          exp_nw.push_back(k == 7 ? w + 1 : -1);
        end
      end
    end
  endtask

  // start a frame and follow it slot by slot; optional abort / restart / reset injection
  task automatic run_frame(input bit fs, input int abort_at, input int restart_at, input int rst_at,
                           output int n_strobe, output int n_done);
    int gap, cyc, slot;
    logic [TX_W-1:0] last;
    bit stop;
    mem_seed = int'($urandom_range(0, 31));
    build_expected(fs);
    n_strobe = 0; n_done = 0; gap = 0; cyc = 0; stop = 1'b0; last = '0;
    bus.frame_sel = fs;
    bus.start = 1'b1;
    @(negedge Cclk);
    bus.start = 1'b0;
    bus.frame_sel = 1'($urandom_range(0, 1));
    while (!stop) begin
      if (bus.tx_valid) begin
        checks++;
        if (n_strobe >= exp_q.size()) begin
          errors++;
          $display("FAIL extra_strobe: strobe %0d seen, only %0d expected", n_strobe, exp_q.size());
        end else if (bus.tx_data !== exp_q[n_strobe]) begin
          errors++;
          $display("FAIL slot_%0d_data: got %h, want %h", n_strobe, bus.tx_data, exp_q[n_strobe]);
        end
        checks++;
        if (n_strobe == 0) begin
          if (bus.line_count !== 12'd0) begin
            errors++;
            $display("FAIL line_count_start: got %0d, want 0", bus.line_count);
          end
        end else if (gap != SP) begin
          errors++;
          $display("FAIL strobe_spacing_%0d: got %0d, want %0d", n_strobe, gap, SP);
        end
        last = bus.tx_data;
        gap = 0;
        n_strobe++;
      end else if (bus.busy) begin
        checks++;
        if (bus.tx_data !== last) begin
          errors++;
          $display("FAIL tx_data_hold_%0d: got %h, want %h", n_strobe - 1, bus.tx_data, last);
        end
      end
      slot = n_strobe - 1;
      if (gap == SP - 3 && slot >= 0 && slot < exp_nw.size() && exp_nw[slot] >= 0) begin
        checks++;
        if (bus.mem_raddr !== RA_W'(exp_nw[slot] / 2) || bus.mem_rsel !== 1'(exp_nw[slot] % 2)) begin
          errors++;
          $display("FAIL prefetch_slot_%0d: got addr %0d sel %0d, want addr %0d sel %0d",
                   slot, bus.mem_raddr, bus.mem_rsel, exp_nw[slot] / 2, exp_nw[slot] % 2);
        end
      end
      if (bus.done) begin
        n_done++;
        stop = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_data !== '0) begin
          errors++;
          $display("FAIL done_idle: got busy %0d data %h, want 0 and 0", bus.busy, bus.tx_data);
        end
      end
      if (!stop && slot == abort_at && gap == 2) begin
        bus.abort = 1'b1;
        @(negedge Cclk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.tx_data !== '0 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL abort_idle: got busy %0d valid %0d data %h done %0d, want all 0",
                   bus.busy, bus.tx_valid, bus.tx_data, bus.done);
        end
        stop = 1'b1;
      end
      if (!stop && slot == rst_at && gap == 1) begin
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.tx_valid, bus.done, bus.tx_data, bus.line_count, bus.frame_count,
             bus.mem_raddr, bus.mem_rsel} !== '0) begin
          errors++;
          $display("FAIL reset_outputs: got busy %0d valid %0d done %0d data %h lines %0d frames %0d addr %0d, want all 0",
                   bus.busy, bus.tx_valid, bus.done, bus.tx_data, bus.line_count, bus.frame_count, bus.mem_raddr);
        end
        @(negedge Cclk);
        @(negedge Cclk);
        rstn = 1'b1;
        stop = 1'b1;
      end
      bus.start = (!stop && slot == restart_at && gap == 1);
      gap++;
      if (!stop) begin
        cyc++;
        if (cyc > 1000) begin
          checks++;
          errors++;
          $display("FAIL frame_timeout: got %0d strobes after %0d cycles, want done", n_strobe, cyc);
          stop = 1'b1;
        end else begin
          @(negedge Cclk);
        end
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic idle_watch(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Cclk);
      if (bus.tx_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: got %0d active cycles, want 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.frame_sel = 1'b0;
    repeat (3) @(negedge Cclk);
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy %0d valid %0d done %0d, want 0", bus.busy, bus.tx_valid, bus.done);
    end
    checks++;
    if (bus.tx_data !== '0) begin
      errors++;
      $display("FAIL reset_tx_data: got %h, want 0", bus.tx_data);
    end
    checks++;
    if (bus.line_count !== 12'd0 || bus.frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d, want 0/0", bus.line_count, bus.frame_count);
    end
    checks++;
    if (bus.mem_raddr !== '0 || bus.mem_rsel !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_port: got %0d/%0d, want 0/0", bus.mem_raddr, bus.mem_rsel);
    end
    rstn = 1'b1;
    @(negedge Cclk);
  endtask

  task automatic test_frame(input bit fs, input int restart_at, input int frames_exp);
    int ns, nd;
    run_frame(fs, -1, restart_at, -1, ns, nd);
    checks++;
    if (ns != SLOTS) begin
      errors++;
      $display("FAIL frame_strobes: got %0d, want %0d", ns, SLOTS);
    end
    checks++;
    if (nd != 1 || bus.line_count !== 12'd4) begin
      errors++;
      $display("FAIL frame_end: got done %0d lines %0d, want 1 and 4", nd, bus.line_count);
    end
    checks++;
    if (bus.frame_count !== 16'(frames_exp)) begin
      errors++;
      $display("FAIL frame_count: got %0d, want %0d", bus.frame_count, frames_exp);
    end
    idle_watch("after_done_quiet", 20);
  endtask

  task automatic test_abort();
    int ns, nd;
    run_frame(1'b1, 45, -1, -1, ns, nd);
    checks++;
    if (nd != 0 || bus.frame_count !== 16'd2 || bus.line_count !== 12'd1) begin
      errors++;
      $display("FAIL abort_counts: got done %0d frames %0d lines %0d, want 0, 2, 1",
               nd, bus.frame_count, bus.line_count);
    end
    idle_watch("abort_quiet", 10);
    test_frame(1'($urandom_range(0, 1)), -1, 3);
  endtask

  task automatic test_reset_mid_hsync();
    int ns, nd;
    run_frame(1'b1, -1, -1, 35, ns, nd);
    @(negedge Cclk);
    checks++;
    if (bus.frame_count !== 16'd0 || bus.line_count !== 12'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got frames %0d lines %0d busy %0d, want 0", bus.frame_count, bus.line_count, bus.busy);
    end
    test_frame(1'b0, -1, 1);
  endtask

  task automatic test_start_abort_same();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge Cclk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_same: got busy %0d valid %0d, want 0 and 0", bus.busy, bus.tx_valid);
    end
    idle_watch("start_abort_quiet", 10);
    checks++;
    if (bus.frame_count !== 16'd1) begin
      errors++;
      $display("FAIL start_abort_frames: got %0d, want 1", bus.frame_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem_seed = 0;
    test_reset();
    test_frame(1'b1, -1, 1);
    test_frame(1'b0, 50, 2);
    test_abort();
    test_reset_mid_hsync();
    test_start_abort_same();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
